// File: rtl/hov_stream_queue_if.sv
// Host/core bus bundle for hov_stream_queue.
// master = host/core side, slave = the queue.
interface hov_stream_queue_if #(
  parameter int DATA_W = 12,
  parameter int BUS_W  = 6,
  parameter int DEPTH  = 4,
  parameter int NCH    = 2
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW   = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [BUS_W-1:0]      wr_data;
  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_adv;
  logic                  out_push;
  logic [CH_W-1:0]       out_sel;
  logic [DATA_W-1:0]     out_data;
  logic                  rd_en;
  logic [DATA_W-1:0]     rd_data;
  logic [CH_W-1:0]       rd_sel;
  logic                  rd_valid;
  logic [NCH*LW-1:0]     in_level;
  logic [2:0]            err_flags;
  logic                  clr_flags;

  modport master (
    output wr_en, wr_ch, wr_data, in_adv,
    output out_push, out_sel, out_data,
    output rd_en, clr_flags,
    input  in_data, in_valid, in_level,
    input  rd_data, rd_sel, rd_valid, err_flags
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, in_adv,
    input  out_push, out_sel, out_data,
    input  rd_en, clr_flags,
    output in_data, in_valid, in_level,
    output rd_data, rd_sel, rd_valid, err_flags
  );
endinterface

// File: rtl/hov_stream_queue.sv
// Host<->Hovalaag I/O buffer: chunked per-channel input
// FIFOs plus a channel-tagged output FIFO.
module hov_stream_queue #(
  parameter int DATA_W = 12,
  parameter int BUS_W  = 6,
  parameter int DEPTH  = 4,
  parameter int NCH    = 2
) (
  input logic              inv_clk,
  input logic              reset,
  hov_stream_queue_if.slave bus
);
  localparam int CHUNKS = DATA_W / BUS_W;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int OW     = CH_W + DATA_W;

  typedef logic [DATA_W-1:0] word_t;

  word_t         imem_q [NCH][DEPTH];
  logic [PW-1:0] irp_q [NCH];
  logic [PW-1:0] irp_d [NCH];
  logic [PW-1:0] iwp_q [NCH];
  logic [PW-1:0] iwp_d [NCH];
  logic [LW-1:0] ilv_q [NCH];
  logic [LW-1:0] ilv_d [NCH];
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  word_t         asm_q [NCH];
  word_t         asm_d [NCH];
  word_t         iword [NCH];
  logic [NCH-1:0] iwe;

  logic [OW-1:0] omem_q [DEPTH];
  logic [PW-1:0] orp_q, orp_d;
  logic [PW-1:0] owp_q, owp_d;
  logic [LW-1:0] olv_q, olv_d;
  logic          owe;
  logic [2:0]    err_q, err_d;

  always_comb begin : next_state
    logic done, pop, ok, opop;
    done  = 1'b0;
    pop   = 1'b0;
    ok    = 1'b0;
    opop  = 1'b0;
    iwe   = '0;
    err_d = bus.clr_flags ? 3'b000 : err_q;
    for (int c = 0; c < NCH; c++) begin
      irp_d[c] = irp_q[c];
      iwp_d[c] = iwp_q[c];
      cnt_d[c] = cnt_q[c];
      asm_d[c] = asm_q[c];
      iword[c] = asm_q[c];
      done     = 1'b0;
      if (bus.wr_en && 32'(bus.wr_ch) == c) begin
        iword[c][BUS_W*cnt_q[c] +: BUS_W] = bus.wr_data;
        asm_d[c] = iword[c];
        done     = (32'(cnt_q[c]) == CHUNKS - 1);
        cnt_d[c] = done ? '0 : cnt_q[c] + 1'b1;
      end
      // a pop frees the slot a same-cycle push needs
      pop    = bus.in_adv[c] && (ilv_q[c] != '0);
      ok     = done && (ilv_q[c] != LW'(DEPTH) || pop);
      iwe[c] = ok;
      if (bus.in_adv[c] && ilv_q[c] == '0) err_d[1] = 1'b1;
      if (done && !ok) err_d[0] = 1'b1;
      if (pop) irp_d[c] = irp_q[c] + 1'b1;
      if (ok)  iwp_d[c] = iwp_q[c] + 1'b1;
      ilv_d[c] = ilv_q[c] + LW'(ok) - LW'(pop);
    end
    orp_d = orp_q;
    owp_d = owp_q;
    opop  = bus.rd_en && (olv_q != '0);
    owe   = bus.out_push && (olv_q != LW'(DEPTH) || bus.rd_en);
    if (bus.out_push && !owe) err_d[2] = 1'b1;
    if (opop) orp_d = orp_q + 1'b1;
    if (owe)  owp_d = owp_q + 1'b1;
    olv_d = olv_q + LW'(owe) - LW'(opop);
  end

  always_ff @(posedge inv_clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        irp_q[c] <= '0;
        iwp_q[c] <= '0;
        ilv_q[c] <= '0;
        cnt_q[c] <= '0;
        asm_q[c] <= '0;
      end
      orp_q <= '0;
      owp_q <= '0;
      olv_q <= '0;
      err_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        irp_q[c] <= irp_d[c];
        iwp_q[c] <= iwp_d[c];
        ilv_q[c] <= ilv_d[c];
        cnt_q[c] <= cnt_d[c];
        asm_q[c] <= asm_d[c];
      end
      orp_q <= orp_d;
      owp_q <= owp_d;
      olv_q <= olv_d;
      err_q <= err_d;
    end
  end

  // storage needs no reset: heads are masked while empty
  always_ff @(posedge inv_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (iwe[c] && !reset) imem_q[c][iwp_q[c]] <= iword[c];
    end
    if (owe && !reset) omem_q[owp_q] <= {bus.out_sel, bus.out_data};
  end

  always_comb begin : outputs
    bus.in_data  = '0;
    bus.in_valid = '0;
    bus.in_level = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.in_valid[c] = (ilv_q[c] != '0);
      bus.in_level[c*LW +: LW] = ilv_q[c];
      if (ilv_q[c] != '0) begin
        bus.in_data[c*DATA_W +: DATA_W] = imem_q[c][irp_q[c]];
      end
    end
    bus.rd_valid  = (olv_q != '0);
    bus.rd_sel    = '0;
    bus.rd_data   = '0;
    if (olv_q != '0) {bus.rd_sel, bus.rd_data} = omem_q[orp_q];
    bus.err_flags = err_q;
  end
endmodule

// File: tb/tb_hov_stream_queue.sv
// Table vectors, corner sequences and a queue-based
// random reference check for hov_stream_queue.
module tb_hov_stream_queue;
  localparam int DATA_W = 12;
  localparam int BUS_W  = 6;
  localparam int DEPTH  = 4;
  localparam int NCH    = 2;
  localparam int CHUNKS = DATA_W / BUS_W;

  logic inv_clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 inv_clk = ~inv_clk;

  hov_stream_queue_if #(
    .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .NCH(NCH)
  ) bus ();

  hov_stream_queue #(
    .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .NCH(NCH)
  ) dut (
    .inv_clk(inv_clk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic        rst, wen, wch;
    logic [5:0]  wd;
    logic [1:0]  adv;
    logic        op, os;
    logic [11:0] od;
    logic        ren, clr;
    logic [11:0] e0, e1;
    logic [1:0]  ev;
    logic [2:0]  l0, l1;
    logic        rv, rs;
    logic [11:0] rd;
    logic [2:0]  er;
  } vec_t;

  vec_t tbl[$];

  logic [11:0] iq [NCH][$];
  logic [12:0] oq[$];
  int          mcnt [NCH];
  logic [11:0] masm [NCH];
  logic [2:0]  merr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic add(
    input logic rst, input logic wen, input logic wch,
    input logic [5:0] wd, input logic [1:0] adv,
    input logic op, input logic os, input logic [11:0] od,
    input logic ren, input logic clr,
    input logic [11:0] e0, input logic [11:0] e1,
    input logic [1:0] ev, input logic [2:0] l0,
    input logic [2:0] l1, input logic rv, input logic rs,
    input logic [11:0] rd, input logic [2:0] er);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wch = wch; v.wd = wd;
    v.adv = adv; v.op = op; v.os = os; v.od = od;
    v.ren = ren; v.clr = clr; v.e0 = e0; v.e1 = e1;
    v.ev = ev; v.l0 = l0; v.l1 = l1; v.rv = rv;
    v.rs = rs; v.rd = rd; v.er = er;
    tbl.push_back(v);
  endtask

  // Reference: whole words in queues, flags from event rules.
  task automatic model_step();
    logic [2:0]  f;
    logic [11:0] w;
    logic        done;
    int          sh;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        iq[c].delete();
        mcnt[c] = 0;
        masm[c] = '0;
      end
      oq.delete();
      merr = '0;
      return;
    end
    f = bus.clr_flags ? 3'b000 : merr;
    for (int c = 0; c < NCH; c++) begin
      done = 1'b0;
      w    = '0;
      if (bus.wr_en && int'(bus.wr_ch) == c) begin
        sh = BUS_W * mcnt[c];
        masm[c] = (masm[c] & ~(12'h03F << sh))
                | (12'(bus.wr_data) << sh);
        mcnt[c]++;
        if (mcnt[c] == CHUNKS) begin
          done    = 1'b1;
          w       = masm[c];
          mcnt[c] = 0;
        end
      end
      if (bus.in_adv[c]) begin
        if (iq[c].size() == 0) f[1] = 1'b1;
        else void'(iq[c].pop_front());
      end
      if (done) begin
        if (iq[c].size() < DEPTH) iq[c].push_back(w);
        else f[0] = 1'b1;
      end
    end
    if (bus.rd_en && oq.size() > 0) void'(oq.pop_front());
    if (bus.out_push) begin
      if (oq.size() < DEPTH) oq.push_back({bus.out_sel, bus.out_data});
      else f[2] = 1'b1;
    end
    merr = f;
  endtask

  task automatic drive(
    input logic rst, input logic wen, input logic wch,
    input logic [5:0] wd, input logic [1:0] adv,
    input logic op, input logic os, input logic [11:0] od,
    input logic ren, input logic clr);
    reset         = rst;
    bus.wr_en     = wen;
    bus.wr_ch     = wch;
    bus.wr_data   = wd;
    bus.in_adv    = adv;
    bus.out_push  = op;
    bus.out_sel   = os;
    bus.out_data  = od;
    bus.rd_en     = ren;
    bus.clr_flags = clr;
    model_step();
    @(posedge inv_clk);
    #1;
  endtask

  task automatic chk_model();
    logic [23:0] ed;
    logic [1:0]  ev;
    logic [5:0]  el;
    logic [12:0] eo;
    ed = '0;
    ev = '0;
    el = '0;
    eo = '0;
    for (int c = 0; c < NCH; c++) begin
      el[c*3 +: 3] = 3'(iq[c].size());
      if (iq[c].size() > 0) begin
        ev[c] = 1'b1;
        ed[c*12 +: 12] = iq[c][0];
      end
    end
    if (oq.size() > 0) eo = oq[0];
    chk("rnd_in_data", 32'(bus.in_data), 32'(ed));
    chk("rnd_in_valid", 32'(bus.in_valid), 32'(ev));
    chk("rnd_in_level", 32'(bus.in_level), 32'(el));
    chk("rnd_rd_valid", 32'(bus.rd_valid), 32'(oq.size() > 0));
    chk("rnd_rd_head", 32'({bus.rd_sel, bus.rd_data}), 32'(eo));
    chk("rnd_err", 32'(bus.err_flags), 32'(merr));
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_ch = 0; bus.wr_data = 0; bus.in_adv = 0;
    bus.out_push = 0; bus.out_sel = 0; bus.out_data = 0;
    bus.rd_en = 0; bus.clr_flags = 0;
    // rst wen ch wd adv | op os od ren clr | e0 e1 ev l0 l1 rv rs rd er
    add(1,1,0,'h3F,0, 0,0,0,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(0,1,0,'h05,0, 0,0,0,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(0,1,0,'h2A,0, 0,0,0,0,0, 'hA85,'h000,1,1,0, 0,0,'h000,0);
    add(0,1,1,'h01,0, 0,0,0,0,0, 'hA85,'h000,1,1,0, 0,0,'h000,0);
    add(0,1,1,'h01,0, 0,0,0,0,0, 'hA85,'h041,3,1,1, 0,0,'h000,0);
    add(0,1,1,'h02,0, 0,0,0,0,0, 'hA85,'h041,3,1,1, 0,0,'h000,0);
    add(0,1,1,'h02,0, 0,0,0,0,0, 'hA85,'h041,3,1,2, 0,0,'h000,0);
    add(0,1,1,'h03,0, 0,0,0,0,0, 'hA85,'h041,3,1,2, 0,0,'h000,0);
    add(0,1,1,'h03,0, 0,0,0,0,0, 'hA85,'h041,3,1,3, 0,0,'h000,0);
    add(0,1,1,'h04,0, 0,0,0,0,0, 'hA85,'h041,3,1,3, 0,0,'h000,0);
    add(0,1,1,'h04,0, 0,0,0,0,0, 'hA85,'h041,3,1,4, 0,0,'h000,0);
    add(0,1,1,'h05,0, 0,0,0,0,0, 'hA85,'h041,3,1,4, 0,0,'h000,0);
    add(0,1,1,'h05,0, 0,0,0,0,0, 'hA85,'h041,3,1,4, 0,0,'h000,1);
    add(0,0,0,'h00,1, 0,0,0,0,0, 'h000,'h041,2,0,4, 0,0,'h000,1);
    add(0,0,0,'h00,1, 0,0,0,0,0, 'h000,'h041,2,0,4, 0,0,'h000,3);
    add(0,0,0,'h00,0, 0,0,0,0,1, 'h000,'h041,2,0,4, 0,0,'h000,0);
    add(0,1,0,'h11,0, 0,0,0,0,0, 'h000,'h041,2,0,4, 0,0,'h000,0);
    add(0,1,0,'h01,0, 0,0,0,0,0, 'h051,'h041,3,1,4, 0,0,'h000,0);
    add(0,1,0,'h12,0, 0,0,0,0,0, 'h051,'h041,3,1,4, 0,0,'h000,0);
    add(0,1,0,'h01,0, 0,0,0,0,0, 'h051,'h041,3,2,4, 0,0,'h000,0);
    add(0,1,0,'h13,0, 0,0,0,0,0, 'h051,'h041,3,2,4, 0,0,'h000,0);
    add(0,1,0,'h01,0, 0,0,0,0,0, 'h051,'h041,3,3,4, 0,0,'h000,0);
    add(0,1,0,'h14,0, 0,0,0,0,0, 'h051,'h041,3,3,4, 0,0,'h000,0);
    add(0,1,0,'h01,0, 0,0,0,0,0, 'h051,'h041,3,4,4, 0,0,'h000,0);
    add(0,1,0,'h15,0, 0,0,0,0,0, 'h051,'h041,3,4,4, 0,0,'h000,0);
    add(0,1,0,'h01,1, 0,0,0,0,0, 'h052,'h041,3,4,4, 0,0,'h000,0);
    add(0,0,0,'h00,0, 1,1,'h123,0,0, 'h052,'h041,3,4,4, 1,1,'h123,0);
    add(0,0,0,'h00,0, 1,0,'hFFF,0,0, 'h052,'h041,3,4,4, 1,1,'h123,0);
    add(0,0,0,'h00,0, 0,0,'h000,1,0, 'h052,'h041,3,4,4, 1,0,'hFFF,0);
    add(0,0,0,'h00,0, 0,0,'h000,1,0, 'h052,'h041,3,4,4, 0,0,'h000,0);
    add(0,0,0,'h00,0, 0,0,'h000,1,0, 'h052,'h041,3,4,4, 0,0,'h000,0);
    add(0,0,0,'h00,0, 1,0,'h001,0,0, 'h052,'h041,3,4,4, 1,0,'h001,0);
    add(0,0,0,'h00,0, 1,0,'h002,0,0, 'h052,'h041,3,4,4, 1,0,'h001,0);
    add(0,0,0,'h00,0, 1,0,'h003,0,0, 'h052,'h041,3,4,4, 1,0,'h001,0);
    add(0,0,0,'h00,0, 1,0,'h004,0,0, 'h052,'h041,3,4,4, 1,0,'h001,0);
    add(0,0,0,'h00,0, 1,1,'h005,0,0, 'h052,'h041,3,4,4, 1,0,'h001,4);
    add(0,0,0,'h00,0, 1,1,'h006,1,0, 'h052,'h041,3,4,4, 1,0,'h002,4);
    add(1,0,0,'h00,0, 0,0,'h000,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(0,1,1,'h3F,0, 0,0,'h000,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(1,0,0,'h00,0, 0,0,'h000,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(0,1,1,'h01,0, 0,0,'h000,0,0, 'h000,'h000,0,0,0, 0,0,'h000,0);
    add(0,1,1,'h00,0, 0,0,'h000,0,0, 'h000,'h001,2,0,1, 0,0,'h000,0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.wen, v.wch, v.wd, v.adv,
            v.op, v.os, v.od, v.ren, v.clr);
      chk($sformatf("v%0d_in_data", i), 32'(bus.in_data), 32'({v.e1, v.e0}));
      chk($sformatf("v%0d_in_valid", i), 32'(bus.in_valid), 32'(v.ev));
      chk($sformatf("v%0d_in_level", i), 32'(bus.in_level), 32'({v.l1, v.l0}));
      chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(v.rv));
      chk($sformatf("v%0d_rd_sel", i), 32'(bus.rd_sel), 32'(v.rs));
      chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(v.rd));
      chk($sformatf("v%0d_err", i), 32'(bus.err_flags), 32'(v.er));
    end

    // underflow on ch0 while its word completes: word kept
    drive(0,1,0,'h07,2'b00, 0,0,'h000,0,0);
    chk("seq_partial_lvl", 32'(bus.in_level), 32'({3'd1, 3'd0}));
    drive(0,1,0,'h00,2'b01, 0,0,'h000,0,0);
    chk("seq_unf_push_data", 32'(bus.in_data), 32'({12'h001, 12'h007}));
    chk("seq_unf_push_lvl", 32'(bus.in_level), 32'({3'd1, 3'd1}));
    chk("seq_unf_push_err", 32'(bus.err_flags), 32'(3'b010));
    // empty output FIFO: push with rd_en keeps the push
    drive(0,0,0,'h00,2'b00, 1,1,'hABC,1,0);
    chk("seq_oempty_valid", 32'(bus.rd_valid), 32'(1));
    chk("seq_oempty_head", 32'({bus.rd_sel, bus.rd_data}), 32'({1'b1, 12'hABC}));
    // clear with no event, then clear racing an underflow
    drive(0,0,0,'h00,2'b11, 0,0,'h000,0,1);
    chk("seq_clr_err", 32'(bus.err_flags), 32'(3'b000));
    chk("seq_clr_valid", 32'(bus.in_valid), 32'(2'b00));
    drive(0,0,0,'h00,2'b01, 0,0,'h000,0,1);
    chk("seq_clr_vs_unf", 32'(bus.err_flags), 32'(3'b010));

    drive(1,0,0,'h00,2'b00, 0,0,'h000,0,0);
    chk_model();
    for (int i = 0; i < 3000; i++) begin
      int pw, pa, pp, pr;
      pw = (i < 1500) ? 80 : 30;
      pa = (i < 1500) ? 15 : 55;
      pp = (i < 1500) ? 55 : 25;
      pr = (i < 1500) ? 25 : 60;
      drive(1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 99) < pw),
            1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)),
            {1'($urandom_range(0, 99) < pa), 1'($urandom_range(0, 99) < pa)},
            1'($urandom_range(0, 99) < pp),
            1'($urandom_range(0, 1)),
            12'($urandom_range(0, 4095)),
            1'($urandom_range(0, 99) < pr),
            1'($urandom_range(0, 39) == 0));
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
